// File: rtl/ras_pred_if.sv
// Fetch/decode side bus of the return-address stack predictor.
// The master drives the decoded instruction fields; the slave returns prediction and status.
interface ras_pred_if #(parameter int AW = 3);
  logic          en;
  logic          flush;
  logic [5:0]    op;
  logic [5:0]    funct;
  logic [4:0]    rs;
  logic [29:0]   pc;
  logic [31:0]   gpra;
  logic          pred_valid;
  logic [29:0]   pred_pc;
  logic          mispredict;
  logic [AW:0]   count;
  logic [15:0]   miss_cnt;

  modport master (
    output en, flush, op, funct, rs, pc, gpra,
    input  pred_valid, pred_pc, mispredict, count, miss_cnt
  );

  modport slave (
    input  en, flush, op, funct, rs, pc, gpra,
    output pred_valid, pred_pc, mispredict, count, miss_cnt
  );
endinterface

// File: rtl/ras_pred.sv
// Return-address stack: pushes link addresses on jal/jalr, predicts jr $31 targets,
// and checks each prediction against the architectural register value.
module ras_pred #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input logic     clk,
  input logic     rst_n,
  ras_pred_if.slave bus
);
  localparam logic [AW:0]   FULL  = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] ONE_P = 1;

  logic [29:0]   stk_q [DEPTH];
  logic [29:0]   stk_d [DEPTH];
  logic [AW-1:0] tp_q, tp_d, top_idx;
  logic [AW:0]   count_q, count_d;
  logic          mispredict_q, mispredict_d;
  logic [15:0]   miss_cnt_q, miss_cnt_d;
  logic          is_push, is_pop, pop_ok, miss;
  logic [29:0]   top_val;
  logic          unused_gpra_lo;

  assign unused_gpra_lo = ^bus.gpra[1:0];

  always_comb begin
    is_push = bus.en && ((bus.op == 6'b000011) ||
                         (bus.op == 6'b000000 && bus.funct == 6'b001001));
    is_pop  = bus.en && (bus.op == 6'b000000) && (bus.funct == 6'b001000) &&
              (bus.rs == 5'd31);
    top_idx = tp_q - ONE_P;
    top_val = stk_q[top_idx];
    pop_ok  = is_pop && (count_q != '0);
    miss    = (top_val != bus.gpra[31:2]);
  end

  assign bus.pred_valid = pop_ok;
  assign bus.pred_pc    = top_val;
  assign bus.mispredict = mispredict_q;
  assign bus.count      = count_q;
  assign bus.miss_cnt   = miss_cnt_q;

  always_comb begin
    stk_d        = stk_q;
    tp_d         = tp_q;
    count_d      = count_q;
    mispredict_d = 1'b0;
    miss_cnt_d   = miss_cnt_q;
    // flush wins over push/pop and ignores en; entries are left in place
    if (bus.flush) begin
      tp_d    = '0;
      count_d = '0;
    end else if (is_push) begin
      stk_d[tp_q] = bus.pc + 30'd1;
      tp_d        = tp_q + ONE_P;
      count_d     = (count_q == FULL) ? count_q : count_q + 1'b1;
    end else if (pop_ok) begin
      tp_d         = top_idx;
      count_d      = count_q - 1'b1;
      mispredict_d = miss;
      if (miss && miss_cnt_q != 16'hFFFF) miss_cnt_d = miss_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stk_q[i] <= '0;
      tp_q         <= '0;
      count_q      <= '0;
      mispredict_q <= 1'b0;
      miss_cnt_q   <= '0;
    end else begin
      stk_q        <= stk_d;
      tp_q         <= tp_d;
      count_q      <= count_d;
      mispredict_q <= mispredict_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end
endmodule

// File: tb/tb_ras_pred.sv
// Bench for ras_pred: directed scenarios plus randomized traffic against a queue-based stack model.
module tb_ras_pred;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam logic [5:0] OP_SPEC = 6'b000000;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_JALR = 6'b001001;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ras_pred_if #(.AW(AW)) bus();
  ras_pred #(.DEPTH(DEPTH), .AW(AW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_cmp  = 0;
  int n_fail = 0;

  // reference model: the live stack as a queue, newest at the back
  logic [29:0] mq[$];
  int          m_miss;
  logic        m_mis;
  logic        exp_pv;
  logic [29:0] exp_pp;

  logic        obs_pv, obs_mis;
  logic [29:0] obs_pp;
  logic [AW:0] obs_cnt;
  logic [15:0] obs_miss;

  task automatic model_reset();
    mq.delete();
    m_miss = 0;
    m_mis  = 1'b0;
  endtask

  // drive one instruction for one cycle; capture combinational outputs mid-cycle
  // and registered outputs just after the edge, while stepping the model
  task automatic cycle(input logic en, input logic flush, input logic [5:0] op,
                       input logic [5:0] funct, input logic [4:0] rs,
                       input logic [29:0] pc, input logic [31:0] gpra);
    logic push, pop;
    logic [29:0] v;
    bus.en = en; bus.flush = flush; bus.op = op; bus.funct = funct;
    bus.rs = rs; bus.pc = pc; bus.gpra = gpra;
    push   = en && (op == OP_JAL || (op == OP_SPEC && funct == FN_JALR));
    pop    = en && op == OP_SPEC && funct == FN_JR && rs == 5'd31;
    exp_pv = pop && (mq.size() > 0);
    exp_pp = (mq.size() > 0) ? mq[$] : 30'h0;
    @(negedge clk);
    obs_pv = bus.pred_valid;
    obs_pp = bus.pred_pc;
    m_mis  = 1'b0;
    if (flush) mq.delete();
    else if (push) begin
      mq.push_back(pc + 30'd1);
      if (mq.size() > DEPTH) void'(mq.pop_front());
    end else if (exp_pv) begin
      v = mq.pop_back();
      if (v != gpra[31:2]) begin
        m_mis = 1'b1;
        if (m_miss < 65535) m_miss++;
      end
    end
    @(posedge clk);
    #1;
    obs_cnt  = bus.count;
    obs_mis  = bus.mispredict;
    obs_miss = bus.miss_cnt;
    bus.en = 1'b0; bus.flush = 1'b0;
  endtask

  task automatic jal(input logic [29:0] pc);
    cycle(1'b1, 1'b0, OP_JAL, 6'h0, 5'd0, pc, 32'h0);
  endtask

  task automatic jalr(input logic [29:0] pc);
    cycle(1'b1, 1'b0, OP_SPEC, FN_JALR, 5'd4, pc, 32'h0);
  endtask

  task automatic jr(input logic [4:0] rs, input logic [31:0] gpra);
    cycle(1'b1, 1'b0, OP_SPEC, FN_JR, rs, 30'h999, gpra);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.en = 1'b1; bus.flush = 1'b0; bus.op = OP_SPEC; bus.funct = FN_JR;
    bus.rs = 5'd31; bus.pc = '0; bus.gpra = '0;
    model_reset();
    #3;
    n_cmp++; if (bus.count !== 4'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
    n_cmp++; if (bus.mispredict !== 1'b0) begin n_fail++; $display("FAIL reset_mispredict got=%b exp=0", bus.mispredict); end
    n_cmp++; if (bus.miss_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_miss_cnt got=%0d exp=0", bus.miss_cnt); end
    n_cmp++; if (bus.pred_valid !== 1'b0) begin n_fail++; $display("FAIL reset_pred_valid got=%b exp=0", bus.pred_valid); end
    bus.en = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    jal(30'h100);
    n_cmp++; if (obs_cnt !== 4'd1) begin n_fail++; $display("FAIL basic_push_count got=%0d exp=1", obs_cnt); end
    jr(5'd31, 32'h00000404);
    n_cmp++; if (obs_pv !== 1'b1) begin n_fail++; $display("FAIL basic_pred_valid got=%b exp=1", obs_pv); end
    n_cmp++; if (obs_pp !== 30'h101) begin n_fail++; $display("FAIL basic_pred_pc got=%h exp=101", obs_pp); end
    n_cmp++; if (obs_mis !== 1'b0) begin n_fail++; $display("FAIL basic_mispredict got=%b exp=0", obs_mis); end
    n_cmp++; if (obs_cnt !== 4'd0) begin n_fail++; $display("FAIL basic_pop_count got=%0d exp=0", obs_cnt); end
    jal(30'h3FFFFFFF);
    jr(5'd31, 32'h0);
    n_cmp++; if (obs_pv !== 1'b1 || obs_pp !== 30'h0) begin n_fail++; $display("FAIL pc_wrap got=%b/%h exp=1/0", obs_pv, obs_pp); end
  endtask

  task automatic test_nesting();
    logic [29:0] pcs [3] = '{30'h10, 30'h20, 30'h30};
    logic [29:0] preds [3] = '{30'h31, 30'h21, 30'h11};
    jal(pcs[0]);
    n_cmp++; if (obs_cnt !== 4'd1) begin n_fail++; $display("FAIL nest_count0 got=%0d exp=1", obs_cnt); end
    jalr(pcs[1]);
    n_cmp++; if (obs_cnt !== 4'd2) begin n_fail++; $display("FAIL nest_count1 got=%0d exp=2", obs_cnt); end
    jal(pcs[2]);
    n_cmp++; if (obs_cnt !== 4'd3) begin n_fail++; $display("FAIL nest_count2 got=%0d exp=3", obs_cnt); end
    for (int i = 0; i < 3; i++) begin
      jr(5'd31, {preds[i], 2'b11});
      n_cmp++; if (obs_pv !== 1'b1 || obs_pp !== preds[i]) begin n_fail++; $display("FAIL nest_pred%0d got=%b/%h exp=1/%h", i, obs_pv, obs_pp, preds[i]); end
      n_cmp++; if (obs_cnt !== 4'(2 - i)) begin n_fail++; $display("FAIL nest_popcount%0d got=%0d exp=%0d", i, obs_cnt, 2 - i); end
      n_cmp++; if (obs_mis !== 1'b0) begin n_fail++; $display("FAIL nest_mis%0d got=%b exp=0", i, obs_mis); end
    end
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 10; i++) begin
      jal(30'(i));
      n_cmp++; if (obs_cnt !== 4'((i > 8) ? 8 : i)) begin n_fail++; $display("FAIL ovf_push%0d_count got=%0d", i, obs_cnt); end
    end
    for (int j = 0; j < 8; j++) begin
      jr(5'd31, {30'(11 - j), 2'b00});
      n_cmp++; if (obs_pv !== 1'b1 || obs_pp !== 30'(11 - j)) begin n_fail++; $display("FAIL ovf_pred%0d got=%b/%h exp=1/%h", j, obs_pv, obs_pp, 11 - j); end
    end
    jr(5'd31, 32'h12345678);
    n_cmp++; if (obs_pv !== 1'b0) begin n_fail++; $display("FAIL ovf_empty_pv got=%b exp=0", obs_pv); end
    n_cmp++; if (obs_cnt !== 4'd0 || obs_mis !== 1'b0) begin n_fail++; $display("FAIL ovf_empty_state got=%0d/%b exp=0/0", obs_cnt, obs_mis); end
  endtask

  task automatic test_mispredict();
    jal(30'h40);
    jr(5'd31, 32'h00000500);
    n_cmp++; if (obs_pp !== 30'h41) begin n_fail++; $display("FAIL mis_pred_pc got=%h exp=41", obs_pp); end
    n_cmp++; if (obs_mis !== 1'b1) begin n_fail++; $display("FAIL mis_pulse got=%b exp=1", obs_mis); end
    n_cmp++; if (obs_miss !== 16'd1) begin n_fail++; $display("FAIL mis_cnt got=%0d exp=1", obs_miss); end
    cycle(1'b0, 1'b0, OP_SPEC, 6'h0, 5'd0, 30'h0, 32'h0);
    n_cmp++; if (obs_mis !== 1'b0) begin n_fail++; $display("FAIL mis_clear got=%b exp=0", obs_mis); end
  endtask

  task automatic test_nonpop_stall();
    jal(30'h7);
    jr(5'd5, 32'h20);
    n_cmp++; if (obs_pv !== 1'b0) begin n_fail++; $display("FAIL jr5_pv got=%b exp=0", obs_pv); end
    n_cmp++; if (obs_cnt !== 4'd1) begin n_fail++; $display("FAIL jr5_count got=%0d exp=1", obs_cnt); end
    cycle(1'b0, 1'b0, OP_JAL, 6'h0, 5'd0, 30'h55, 32'h0);
    n_cmp++; if (obs_cnt !== 4'd1) begin n_fail++; $display("FAIL stall_count got=%0d exp=1", obs_cnt); end
  endtask

  task automatic test_flush_reset();
    jal(30'h60);
    jal(30'h70);
    n_cmp++; if (obs_cnt !== 4'd3) begin n_fail++; $display("FAIL flush_pre_count got=%0d exp=3", obs_cnt); end
    cycle(1'b1, 1'b1, OP_JAL, 6'h0, 5'd0, 30'h80, 32'h0);
    n_cmp++; if (obs_cnt !== 4'd0) begin n_fail++; $display("FAIL flush_count got=%0d exp=0", obs_cnt); end
    jr(5'd31, 32'h204);
    n_cmp++; if (obs_pv !== 1'b0) begin n_fail++; $display("FAIL flush_pop_pv got=%b exp=0", obs_pv); end
    n_cmp++; if (obs_miss !== 16'(m_miss) || m_miss == 0) begin n_fail++; $display("FAIL flush_keeps_miss got=%0d exp=%0d", obs_miss, m_miss); end
    jal(30'h90);
    bus.en = 1'b1; bus.op = OP_JAL; bus.pc = 30'hA0;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_cmp++; if (bus.miss_cnt !== 16'd0) begin n_fail++; $display("FAIL midrst_miss got=%0d exp=0", bus.miss_cnt); end
    n_cmp++; if (bus.count !== 4'd0) begin n_fail++; $display("FAIL midrst_count got=%0d exp=0", bus.count); end
    bus.en = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic en, fl;
    logic [5:0] op, fn;
    logic [4:0] rs;
    logic [31:0] g;
    int k;
    for (int n = 0; n < 600; n++) begin
      k  = $urandom_range(0, 9);
      en = ($urandom_range(0, 9) != 0);
      fl = ($urandom_range(0, 29) == 0);
      rs = 5'd31; fn = FN_JR; op = OP_SPEC;
      g  = $urandom;
      case (k)
        0, 1, 2: op = OP_JAL;
        3:       fn = FN_JALR;
        4, 5, 6: if (mq.size() > 0 && $urandom_range(0, 9) < 7) g = {mq[$], 2'($urandom)};
        7:       rs = 5'($urandom_range(0, 30));
        8:       op = 6'($urandom);
        default: fn = 6'($urandom);
      endcase
      cycle(en, fl, op, fn, rs, 30'($urandom), g);
      n_cmp++; if (obs_pv !== exp_pv) begin n_fail++; $display("FAIL rnd%0d_pv got=%b exp=%b", n, obs_pv, exp_pv); end
      if (exp_pv) begin
        n_cmp++; if (obs_pp !== exp_pp) begin n_fail++; $display("FAIL rnd%0d_pc got=%h exp=%h", n, obs_pp, exp_pp); end
      end
      n_cmp++; if (obs_cnt !== 4'(mq.size())) begin n_fail++; $display("FAIL rnd%0d_count got=%0d exp=%0d", n, obs_cnt, mq.size()); end
      n_cmp++; if (obs_mis !== m_mis) begin n_fail++; $display("FAIL rnd%0d_mis got=%b exp=%b", n, obs_mis, m_mis); end
      n_cmp++; if (obs_miss !== 16'(m_miss)) begin n_fail++; $display("FAIL rnd%0d_miss got=%0d exp=%0d", n, obs_miss, m_miss); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_nesting();
    test_overflow();
    test_mispredict();
    test_nonpop_stall();
    test_flush_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
